// File: rtl/ibex_pkg.sv
// Shared types for the dual-port RAM block requester: geometry, FSM state
// encoding and the latched command record.
package ibex_pkg;

  localparam int unsigned RamWidth = 32;
  localparam int unsigned RamDepth = 128;
  localparam int unsigned RamAw    = $clog2(RamDepth);

  typedef enum logic [2:0] {
    RAM_REQ_IDLE   = 3'd0,
    RAM_REQ_WRITE  = 3'd1,
    RAM_REQ_READ   = 3'd2,
    RAM_REQ_DRAIN  = 3'd3,
    RAM_REQ_VERIFY = 3'd4,
    RAM_REQ_DONE   = 3'd5
  } ram_req_state_e;

  // addr and wdata advance as the command runs; len counts the words still to go.
  typedef struct packed {
    logic                write;
    logic [RamAw-1:0]    addr;
    logic [RamAw:0]      len;
    logic [RamWidth-1:0] wdata;
    logic                incr;
    logic [RamWidth-1:0] wmask;
  } ram_req_cmd_t;

  // Word address successor, wrapping Depth-1 back to 0 even for non power-of-two depths.
  function automatic logic [RamAw-1:0] ram_addr_next(input logic [RamAw-1:0] addr);
    if (addr == RamAw'(RamDepth - 1)) begin
      return '0;
    end
    return addr + RamAw'(1);
  endfunction

endpackage

// File: rtl/prim_ram_2p_rsp_buf.sv
// One-entry response buffer for read data. A push and a pop may happen in the
// same cycle, so a consumer holding ready high sees one word per cycle.
// Handshake: a word is transferred when valid_o && ready_i; the producer only
// pushes when the buffer is empty or is being popped in that cycle, so
// data_o/last_o stay stable while valid_o && !ready_i.
module prim_ram_2p_rsp_buf
  import ibex_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic [RamWidth-1:0] push_data_i,
  input  logic                push_last_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [RamWidth-1:0] data_o,
  output logic                last_o
);

  logic                valid_q;
  logic [RamWidth-1:0] data_q;
  logic                last_q;

  // Fill on push (takes priority, covers push+pop), empty on a pop alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= push_data_i;
      last_q  <= push_last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/prim_ram_2p_requester.sv
// Block-command initiator for one port of the dual-port RAM: fills N words
// with a constant or incrementing pattern, or reads N words out on a
// valid/ready response stream. Used for init, scrub and debug dumps.
// Optional feature macro RAM_REQ_READBACK_EN: every fill write is followed by
// a read of the same address and masked mismatches set a sticky err_o.
// Handshakes: command taken on cmd_valid_i && cmd_ready_o; read word taken on
// rsp_valid_o && rsp_ready_i, with data/last held while not taken.
module prim_ram_2p_requester
  import ibex_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [RamAw-1:0]    cmd_addr_i,
  input  logic [RamAw:0]      cmd_len_i,
  input  logic [RamWidth-1:0] cmd_wdata_i,
  input  logic                cmd_incr_i,
  input  logic [RamWidth-1:0] cmd_wmask_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [RamWidth-1:0] rsp_rdata_o,
  output logic                rsp_last_o,
  output logic                ram_req_o,
  output logic                ram_write_o,
  output logic [RamAw-1:0]    ram_addr_o,
  output logic [RamWidth-1:0] ram_wdata_o,
  output logic [RamWidth-1:0] ram_wmask_o,
  input  logic [RamWidth-1:0] ram_rdata_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  ram_req_state_e   state_q, state_d;
  ram_req_cmd_t     cmd_q, cmd_d;
  logic [RamAw-1:0] last_addr_q, last_addr_d;
  logic             advance;
  logic             last_word;
  logic             buf_push;

`ifdef RAM_REQ_READBACK_EN
  logic err_q, err_d;
  logic rb_mismatch;
  assign rb_mismatch = |((ram_rdata_i ^ cmd_q.wdata) & cmd_q.wmask);
`endif

  assign last_word = (cmd_q.len == (RamAw + 1)'(1));

  // Next-state and RAM/command-side outputs.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_ready_o = 1'b0;
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    buf_push    = 1'b0;
    advance     = 1'b0;
`ifdef RAM_REQ_READBACK_EN
    err_d       = err_q;
`endif

    unique case (state_q)
      RAM_REQ_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          cmd_d.write = cmd_write_i;
          cmd_d.addr  = cmd_addr_i;
          cmd_d.len   = cmd_len_i;
          cmd_d.wdata = cmd_wdata_i;
          cmd_d.incr  = cmd_incr_i;
          cmd_d.wmask = cmd_wmask_i;
`ifdef RAM_REQ_READBACK_EN
          err_d       = 1'b0;
`endif
          if (cmd_len_i == '0) begin
            state_d = RAM_REQ_DONE;
          end else if (cmd_write_i) begin
            state_d = RAM_REQ_WRITE;
          end else begin
            state_d = RAM_REQ_READ;
          end
        end
      end

      RAM_REQ_WRITE: begin
        busy_o      = 1'b1;
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
`ifdef RAM_REQ_READBACK_EN
        // Address and pattern stay put so the check reads back the same word.
        state_d     = RAM_REQ_VERIFY;
`else
        advance     = 1'b1;
        if (last_word) begin
          state_d = RAM_REQ_DONE;
        end
`endif
      end

`ifdef RAM_REQ_READBACK_EN
      RAM_REQ_VERIFY: begin
        busy_o    = 1'b1;
        ram_req_o = 1'b1;
        advance   = 1'b1;
        if (rb_mismatch) begin
          err_d = 1'b1;
        end
        state_d = last_word ? RAM_REQ_DONE : RAM_REQ_WRITE;
      end
`endif

      RAM_REQ_READ: begin
        busy_o = 1'b1;
        // Issue only if the captured word has somewhere to go this cycle.
        if (!rsp_valid_o || rsp_ready_i) begin
          ram_req_o = 1'b1;
          buf_push  = 1'b1;
          advance   = 1'b1;
          if (last_word) begin
            state_d = RAM_REQ_DRAIN;
          end
        end
      end

      RAM_REQ_DRAIN: begin
        busy_o = 1'b1;
        if (!rsp_valid_o || rsp_ready_i) begin
          state_d = RAM_REQ_DONE;
        end
      end

      RAM_REQ_DONE: begin
        done_o  = 1'b1;
        state_d = RAM_REQ_IDLE;
      end

      default: begin
        state_d = RAM_REQ_IDLE;
      end
    endcase

    if (advance) begin
      cmd_d.addr  = ram_addr_next(cmd_q.addr);
      cmd_d.wdata = cmd_q.wdata + {{(RamWidth - 1){1'b0}}, cmd_q.incr};
      cmd_d.len   = cmd_q.len - (RamAw + 1)'(1);
    end
  end

  // The RAM address follows the running pointer while requesting and
  // otherwise shows the last address actually presented.
  assign last_addr_d = ram_req_o ? cmd_q.addr : last_addr_q;
  assign ram_addr_o  = last_addr_d;
  assign ram_wdata_o = ram_write_o ? cmd_q.wdata : '0;
  assign ram_wmask_o = ram_write_o ? cmd_q.wmask : '0;

  // State, command record and address-hold registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RAM_REQ_IDLE;
      cmd_q       <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      last_addr_q <= last_addr_d;
    end
  end

`ifdef RAM_REQ_READBACK_EN
  // Sticky readback error, cleared when the next command is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  prim_ram_2p_rsp_buf u_rsp_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (buf_push),
    .push_data_i (ram_rdata_i),
    .push_last_i (last_word),
    .valid_o     (rsp_valid_o),
    .ready_i     (rsp_ready_i),
    .data_o      (rsp_rdata_o),
    .last_o      (rsp_last_o)
  );

endmodule

// File: tb/tb_prim_ram_2p_requester.sv
// Directed bench for prim_ram_2p_requester with a behavioural RAM model.
module tb_prim_ram_2p_requester;
  import ibex_pkg::*;

  localparam int W  = RamWidth;
  localparam int AW = RamAw;
`ifdef RAM_REQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, cmd_write, cmd_incr;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_len;
  logic [W-1:0]  cmd_wdata, cmd_wmask;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [W-1:0]  rsp_rdata;
  logic          ram_req, ram_write;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata, ram_wmask, ram_rdata;
  logic          busy, done, err;

  prim_ram_2p_requester dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .cmd_wdata_i (cmd_wdata),
    .cmd_incr_i  (cmd_incr),
    .cmd_wmask_i (cmd_wmask),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_last_o  (rsp_last),
    .ram_req_o   (ram_req),
    .ram_write_o (ram_write),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_wmask_o (ram_wmask),
    .ram_rdata_i (ram_rdata),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  // ---------------- RAM model ----------------
  logic [W-1:0] mem [RamDepth];
  logic [W-1:0] rd_force_mask;
  assign ram_rdata = mem[ram_addr] & ~rd_force_mask;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  wr_data_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [W-1:0]  rsp_data_q[$];
  logic          rsp_last_q[$];
  int            req_cyc_q[$];
  int bad_wdata = 0;
  int req_when_full = 0;
  int req_count = 0;

  always @(posedge clk) cyc++;

  // Monitor and RAM write port, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (ram_req && ram_write) begin
        mem[ram_addr] = (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
        wr_addr_q.push_back(ram_addr);
        wr_data_q.push_back(ram_wdata);
      end
      if (ram_req) begin
        req_count++;
        req_cyc_q.push_back(cyc);
      end
      if (!ram_write && ram_wdata != '0) bad_wdata++;
      if (rsp_valid && !rsp_ready && ram_req) req_when_full++;
      if (rsp_valid && rsp_ready) begin
        rsp_data_q.push_back(rsp_rdata);
        rsp_last_q.push_back(rsp_last);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rsp_data_q.delete();
    rsp_last_q.delete();
    req_cyc_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  int acc_cyc;
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW:0] len,
                          input logic [W-1:0] wd, input logic inc, input logic [W-1:0] mask);
    int guard;
    guard = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_wdata = wd;
    cmd_incr  = inc;
    cmd_wmask = mask;
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    acc_cyc   = cyc;
  endtask

  // Returns the cycle (1 = first cycle after accept) in which done_o is seen.
  task automatic wait_done(output int lat, output logic busy1);
    lat   = 0;
    busy1 = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int lat;
    int rc0;
    int unstable;
    int guard;
    logic b1;
    logic [W-1:0] held;
    logic [AW-1:0] exp_addr [4];
    logic exp_last [4];

    exp_addr[0] = 7'h7E; exp_addr[1] = 7'h7F; exp_addr[2] = 7'h00; exp_addr[3] = 7'h01;
    exp_last[0] = 1'b0; exp_last[1] = 1'b0; exp_last[2] = 1'b0; exp_last[3] = 1'b1;
    for (int i = 0; i < RamDepth; i++) mem[i] = 32'h1000_0000 + i;
    rd_force_mask = '0;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_wdata = '0; cmd_incr = 1'b0; cmd_wmask = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_ram_req", 32'(ram_req), 32'd0);
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_ram_wmask", ram_wmask, 32'd0);
    check("rst_rsp", {29'd0, rsp_valid, rsp_last, |rsp_rdata}, 32'd0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill 4 words wrapping past the top of the RAM
    clear_logs();
    send_cmd(1'b1, 7'h7E, 8'd4, 32'hA5A5_0000, 1'b1, 32'hFFFF_FFFF);
    wait_done(lat, b1);
    check("fill_done_latency", 32'(lat), RB ? 32'd9 : 32'd5);
    check("fill_busy_cycle1", 32'(b1), 32'd1);
    check("fill_write_count", 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      check($sformatf("fill_addr%0d", i), 32'(wr_addr_q[i]), 32'(exp_addr[i]));
      check($sformatf("fill_data%0d", i), wr_data_q[i], 32'hA5A5_0000 + i);
    end
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(cmd_ready), 32'd1);
    check("addr_held_idle", 32'(ram_addr), 32'h01);

    // Read back the same 4 words at full throughput
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hA5A5_0000 + i);
    send_cmd(1'b0, 7'h7E, 8'd4, 32'h0, 1'b0, 32'h0);
    wait_done(lat, b1);
    check("read_beats", 32'(rsp_data_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rsp_data_q.size(); i++) begin
      check($sformatf("read_data%0d", i), rsp_data_q[i], exp_q.pop_front());
      check($sformatf("read_last%0d", i), 32'(rsp_last_q[i]), 32'(exp_last[i]));
    end
    check("read_req_count", 32'(req_cyc_q.size()), 32'd4);
    if (req_cyc_q.size() == 4) begin
      check("read_first_access", 32'(req_cyc_q[0]), 32'(acc_cyc));
      for (int i = 1; i < 4; i++)
        check($sformatf("read_req_back2back%0d", i), 32'(req_cyc_q[i]), 32'(req_cyc_q[0] + i));
    end

    // Read 3 words with the consumer stalled after the first beat appears
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    clear_logs();
    exp_q.push_back(32'hA5A5_0001);
    exp_q.push_back(32'hA5A5_0002);
    exp_q.push_back(32'hA5A5_0003);
    send_cmd(1'b0, 7'h7F, 8'd3, 32'h0, 1'b0, 32'h0);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!rsp_valid && guard < 20);
    check("stall_first_valid", 32'(rsp_valid), 32'd1);
    held = rsp_rdata;
    check("stall_first_data", held, 32'hA5A5_0001);
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_rdata !== held || rsp_valid !== 1'b1 || ram_req !== 1'b0) unstable++;
    end
    check("stall_hold_no_req", 32'(unstable), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_done(lat, b1);
    check("stall_done_seen", 32'(lat != 0), 32'd1);
    check("stall_beats", 32'(rsp_data_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < rsp_data_q.size(); i++) begin
      check($sformatf("stall_data%0d", i), rsp_data_q[i], exp_q.pop_front());
      check($sformatf("stall_last%0d", i), 32'(rsp_last_q[i]), (i == 2) ? 32'd1 : 32'd0);
    end
    check("req_while_full", 32'(req_when_full), 32'd0);

    // Zero-length command
    rc0 = req_count;
    send_cmd(1'b1, 7'h05, 8'd0, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF);
    wait_done(lat, b1);
    check("len0_done_latency", 32'(lat), 32'd1);
    check("len0_no_req", 32'(req_count - rc0), 32'd0);
    check("len0_not_busy", 32'(b1), 32'd0);

    // Reset in the middle of a 16-word fill
    send_cmd(1'b1, 7'h10, 8'd16, 32'h5555_0000, 1'b1, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    check("midfill_active", 32'(ram_req & ram_write), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midfill_rst_req", 32'(ram_req), 32'd0);
    check("midfill_rst_idle", {30'd0, cmd_ready, busy}, 32'd2);
    rst = 1'b0;

    // Reset while a read response sits in the buffer
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send_cmd(1'b0, 7'h40, 8'd4, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    check("midread_buffered", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midread_rsp_dropped", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;

    // Fill with bit 3 of the read path stuck at 0
    rd_force_mask = 32'h0000_0008;
    send_cmd(1'b1, 7'h20, 8'd2, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
    wait_done(lat, b1);
    check("rb_fill_latency", 32'(lat), RB ? 32'd5 : 32'd3);
    check("rb_err_set", 32'(err), RB ? 32'd1 : 32'd0);
    repeat (3) @(negedge clk);
    check("rb_err_sticky", 32'(err), RB ? 32'd1 : 32'd0);
    rd_force_mask = '0;
    send_cmd(1'b1, 7'h20, 8'd0, 32'h0, 1'b0, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rb_err_cleared", 32'(err), 32'd0);
    check("rb_clear_cmd_done", 32'(done), 32'd1);

    check("wdata_zero_when_not_writing", 32'(bad_wdata), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
